// File: rtl/snake_pkg.sv
// Shared snake-game definitions: global game-state encoding, BCD digit width,
// and a helper that turns a small decimal constant into two packed BCD digits.
package snake_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [2:0] {
        STATE_IDLE  = 3'd0,
        STATE_PLAY  = 3'd1,
        STATE_PAUSE = 3'd2,
        STATE_OVER  = 3'd3
    } state_t;

    // Two-digit BCD of v (0..99); used at elaboration for the per-event addends.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'((v / 10) % 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: a + b + cin with decimal adjust (+6 when the binary
// sum exceeds 9), producing one BCD digit and a decimal carry.
module bcd_digit_add
    import snake_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] sum,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] raw;

    // Binary add then decimal adjust; raw never exceeds 19 for valid digits.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        if (raw > (BCD_DIGIT_W + 1)'(9)) begin
            sum  = raw[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(6);
            cout = 1'b1;
        end else begin
            sum  = raw[BCD_DIGIT_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_counter_bcd.sv
// Multi-digit BCD score counter for the snake game. Rising edges on target_ate
// and bonus_ate add fixed point values while playing; the score clears in IDLE,
// clamps at all-nines and a session high score is tracked until reset.
module score_counter_bcd
    import snake_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned POINTS       = 1,
    parameter int unsigned BONUS_POINTS = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    game_state,
    input  logic                          target_ate,
    input  logic                          bonus_ate,
    output logic [BCD_DIGIT_W*DIGITS-1:0] score,
    output logic [BCD_DIGIT_W*DIGITS-1:0] high_score,
    output logic                          units_tick,
    output logic                          saturated,
    output logic                          new_high
);

    localparam int unsigned W      = BCD_DIGIT_W * DIGITS;
    localparam logic [7:0]  ADD_T  = to_bcd2(POINTS);
    localparam logic [7:0]  ADD_B  = to_bcd2(BONUS_POINTS);
    localparam logic [7:0]  ADD_TB = to_bcd2(POINTS + BONUS_POINTS);
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic                      t_q;
    logic                      b_q;
    logic                      t_ev;
    logic                      b_ev;
    logic [7:0]                add_bcd;
    logic [W+BCD_DIGIT_W-1:0]  addend;
    logic [DIGITS:0]           carry;
    logic [W-1:0]              sum;
    logic                      overflow;
    logic [W-1:0]              score_next;
    logic [W-1:0]              high_next;
    logic                      tick_next;
    logic                      sat_next;
    logic                      nh_next;

    assign t_ev = target_ate & ~t_q;
    assign b_ev = bonus_ate & ~b_q;

    // Input history for edge detection, tracked in every game state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            t_q <= target_ate;
            b_q <= bonus_ate;
        end
    end

    // Select the pre-computed BCD addend for this cycle's events.
    always_comb begin
        unique case ({t_ev, b_ev})
            2'b10:   add_bcd = ADD_T;
            2'b01:   add_bcd = ADD_B;
            2'b11:   add_bcd = ADD_TB;
            default: add_bcd = 8'h00;
        endcase
    end

    // One extra digit of headroom so a two-digit addend is never lost when
    // DIGITS is 1; a non-zero tens digit there counts as overflow.
    assign addend   = (W + BCD_DIGIT_W)'(add_bcd);
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_add u_digit (
            .a    (score[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .b    (addend[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .cin  (carry[i]),
            .sum  (sum[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .cout (carry[i+1])
        );
    end

    assign overflow = carry[DIGITS] | (|addend[W+BCD_DIGIT_W-1:W]);

    // Next score/flags: IDLE clear wins, then a PLAY update, then the
    // high-score compare against the score that will be registered.
    always_comb begin
        score_next = score;
        high_next  = high_score;
        tick_next  = 1'b0;
        sat_next   = saturated;
        nh_next    = new_high;
        if (game_state == STATE_IDLE) begin
            score_next = '0;
            sat_next   = 1'b0;
            nh_next    = 1'b0;
        end else if (game_state == STATE_PLAY && !saturated && (t_ev || b_ev)) begin
            if (overflow) begin
                score_next = ALL_NINES;
                sat_next   = 1'b1;
            end else begin
                score_next = sum;
                tick_next  = carry[1];
            end
        end
        if (score_next > high_score) begin
            high_next = score_next;
            nh_next   = 1'b1;
        end
    end

    // Score, high score and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
            units_tick <= 1'b0;
            saturated  <= 1'b0;
            new_high   <= 1'b0;
        end else begin
            score      <= score_next;
            high_score <= high_next;
            units_tick <= tick_next;
            saturated  <= sat_next;
            new_high   <= nh_next;
        end
    end

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: a 4-digit and a 2-digit instance share clock,
// reset and game state; an integer-arithmetic score model predicts both.
module tb_score_counter_bcd;
    import snake_pkg::*;

    localparam int unsigned D1   = 4;
    localparam int unsigned D2   = 2;
    localparam int unsigned PTS  = 1;
    localparam int unsigned BPTS = 5;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t game_state = STATE_IDLE;
    logic   t1 = 1'b0, b1 = 1'b0, t2 = 1'b0, b2 = 1'b0;

    logic [4*D1-1:0] score1, high1;
    logic [4*D2-1:0] score2, high2;
    logic            tick1, sat1, nh1, tick2, sat2, nh2;

    int vectors = 0;
    int errors  = 0;

    // model state, index 0 = 4-digit instance, 1 = 2-digit instance
    int m_score[2], m_high[2], m_max[2];
    bit m_tick[2], m_sat[2], m_nh[2], m_tq[2], m_bq[2];

    score_counter_bcd #(.DIGITS(D1), .POINTS(PTS), .BONUS_POINTS(BPTS)) u_dut1 (
        .clk(clk), .rst(rst), .game_state(game_state), .target_ate(t1), .bonus_ate(b1),
        .score(score1), .high_score(high1), .units_tick(tick1), .saturated(sat1), .new_high(nh1)
    );

    score_counter_bcd #(.DIGITS(D2), .POINTS(PTS), .BONUS_POINTS(BPTS)) u_dut2 (
        .clk(clk), .rst(rst), .game_state(game_state), .target_ate(t2), .bonus_ate(b2),
        .score(score2), .high_score(high2), .units_tick(tick2), .saturated(sat2), .new_high(nh2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_high[k] = 0; m_tick[k] = 0;
            m_sat[k] = 0; m_nh[k] = 0; m_tq[k] = 0; m_bq[k] = 0;
        end
        m_max[0] = 9999;
        m_max[1] = 99;
    endtask

    // One clock of game rules in decimal arithmetic, using the driven inputs.
    task automatic model_step();
        bit tt[2], bb[2];
        bit te, be;
        int add;
        tt[0] = t1; bb[0] = b1; tt[1] = t2; bb[1] = b2;
        for (int k = 0; k < 2; k++) begin
            te = tt[k] && !m_tq[k];
            be = bb[k] && !m_bq[k];
            m_tq[k] = tt[k];
            m_bq[k] = bb[k];
            m_tick[k] = 0;
            if (game_state == STATE_IDLE) begin
                m_score[k] = 0; m_sat[k] = 0; m_nh[k] = 0;
            end else if (game_state == STATE_PLAY && !m_sat[k] && (te || be)) begin
                add = (te ? PTS : 0) + (be ? BPTS : 0);
                if (m_score[k] + add > m_max[k]) begin
                    m_score[k] = m_max[k];
                    m_sat[k] = 1;
                end else begin
                    m_tick[k] = ((m_score[k] % 10) + (add % 10)) >= 10;
                    m_score[k] = m_score[k] + add;
                end
            end
            if (m_score[k] > m_high[k]) begin
                m_high[k] = m_score[k];
                m_nh[k] = 1;
            end
        end
    endtask

    task automatic cycle(input state_t s, input logic ta, input logic ba,
                         input logic tb2, input logic bb2);
        game_state = s; t1 = ta; b1 = ba; t2 = tb2; b2 = bb2;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1(input logic ta, input logic ba);
        cycle(STATE_PLAY, ta, ba, 1'b0, 1'b0);
        cycle(STATE_PLAY, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        game_state = STATE_PLAY; t1 = 1; b1 = 1; t2 = 1; b2 = 1;
        #1 rst = 1'b1;
        #1;
        vectors++; if (score1 !== '0) begin errors++; $display("FAIL reset_score1: got %h expected 0", score1); end
        vectors++; if (high1 !== '0) begin errors++; $display("FAIL reset_high1: got %h expected 0", high1); end
        vectors++; if ({tick1, sat1, nh1} !== 3'b000) begin errors++; $display("FAIL reset_flags1: got %b expected 000", {tick1, sat1, nh1}); end
        vectors++; if ({score2, high2} !== '0) begin errors++; $display("FAIL reset_dut2: got %h expected 0", {score2, high2}); end
        t1 = 0; b1 = 0; t2 = 0; b2 = 0; game_state = STATE_IDLE;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ten_pulses();
        cycle(STATE_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(STATE_PLAY, 1, 0, 0, 0);
            vectors++;
            if (tick1 !== (i == 9)) begin errors++; $display("FAIL ten_tick_pulse%0d: got %b expected %b", i, tick1, (i == 9)); end
            cycle(STATE_PLAY, 0, 0, 0, 0);
            vectors++;
            if (tick1 !== 1'b0) begin errors++; $display("FAIL ten_tick_low%0d: got %b expected 0", i, tick1); end
        end
        vectors++; if (score1 !== 16'h0010) begin errors++; $display("FAIL ten_score: got %h expected 0010", score1); end
    endtask

    task automatic test_held_and_combined();
        for (int i = 0; i < 20; i++) cycle(STATE_PLAY, 1, 0, 0, 0);
        cycle(STATE_PLAY, 0, 0, 0, 0);
        vectors++; if (score1 !== 16'h0011) begin errors++; $display("FAIL held_score: got %h expected 0011", score1); end
        cycle(STATE_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) pulse1(1, 0);
        vectors++; if (score1 !== 16'h0007) begin errors++; $display("FAIL seven_score: got %h expected 0007", score1); end
        cycle(STATE_PLAY, 1, 1, 0, 0);
        vectors++; if (score1 !== 16'h0013) begin errors++; $display("FAIL both_score: got %h expected 0013", score1); end
        vectors++; if (tick1 !== 1'b1) begin errors++; $display("FAIL both_tick: got %b expected 1", tick1); end
        cycle(STATE_PLAY, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        cycle(STATE_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) begin
            cycle(STATE_PLAY, 0, 0, 0, 1);
            cycle(STATE_PLAY, 0, 0, 0, 0);
        end
        vectors++; if ({sat2, score2} !== {1'b0, 8'h95}) begin errors++; $display("FAIL sat_pre: got %b/%h expected 0/95", sat2, score2); end
        cycle(STATE_PLAY, 0, 0, 0, 1);
        vectors++; if ({sat2, score2} !== {1'b1, 8'h99}) begin errors++; $display("FAIL sat_clamp: got %b/%h expected 1/99", sat2, score2); end
        vectors++; if (tick2 !== 1'b0) begin errors++; $display("FAIL sat_tick: got %b expected 0", tick2); end
        cycle(STATE_PLAY, 0, 0, 0, 0);
        cycle(STATE_PLAY, 0, 0, 1, 0);
        cycle(STATE_PLAY, 0, 0, 0, 0);
        cycle(STATE_PLAY, 0, 0, 0, 1);
        vectors++; if ({sat2, score2, high2} !== {1'b1, 8'h99, 8'h99}) begin errors++; $display("FAIL sat_hold: got %b/%h/%h expected 1/99/99", sat2, score2, high2); end
        cycle(STATE_IDLE, 0, 0, 0, 0);
        vectors++; if ({sat2, score2} !== {1'b0, 8'h00}) begin errors++; $display("FAIL sat_idle: got %b/%h expected 0/00", sat2, score2); end
    endtask

    task automatic test_reset_mid();
        cycle(STATE_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) pulse1(0, 1);
        pulse1(1, 0);
        pulse1(1, 0);
        vectors++; if (score1 !== 16'h0042) begin errors++; $display("FAIL mid_pre: got %h expected 0042", score1); end
        t1 = 1;
        #3 rst = 1'b1;
        #1;
        vectors++; if ({score1, high1} !== 32'h0) begin errors++; $display("FAIL mid_rst_scores: got %h expected 0", {score1, high1}); end
        vectors++; if ({tick1, sat1, nh1} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 000", {tick1, sat1, nh1}); end
        t1 = 0;
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_high_score();
        cycle(STATE_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) pulse1(0, 1);
        vectors++; if ({nh1, high1} !== {1'b1, 16'h0030}) begin errors++; $display("FAIL hs_game1: got %b/%h expected 1/0030", nh1, high1); end
        cycle(STATE_OVER, 0, 0, 0, 0);
        cycle(STATE_IDLE, 0, 0, 0, 0);
        vectors++; if ({nh1, score1, high1} !== {1'b0, 16'h0000, 16'h0030}) begin errors++; $display("FAIL hs_idle: got %b/%h/%h expected 0/0000/0030", nh1, score1, high1); end
        for (int i = 0; i < 6; i++) pulse1(0, 1);
        vectors++; if ({nh1, high1} !== {1'b0, 16'h0030}) begin errors++; $display("FAIL hs_tie: got %b/%h expected 0/0030", nh1, high1); end
        pulse1(1, 0);
        vectors++; if ({nh1, high1} !== {1'b1, 16'h0031}) begin errors++; $display("FAIL hs_game2: got %b/%h expected 1/0031", nh1, high1); end
    endtask

    task automatic test_drop();
        cycle(STATE_PAUSE, 1, 0, 0, 0);
        cycle(STATE_PAUSE, 0, 0, 0, 0);
        cycle(STATE_OVER, 0, 1, 0, 0);
        cycle(STATE_OVER, 0, 0, 0, 0);
        vectors++; if (score1 !== 16'h0031) begin errors++; $display("FAIL drop_pause_over: got %h expected 0031", score1); end
        cycle(STATE_PAUSE, 1, 0, 0, 0);
        cycle(STATE_PLAY, 1, 0, 0, 0);
        vectors++; if (score1 !== 16'h0031) begin errors++; $display("FAIL drop_held_into_play: got %h expected 0031", score1); end
        cycle(STATE_PLAY, 0, 0, 0, 0);
        cycle(STATE_IDLE, 1, 1, 0, 0);
        vectors++; if (score1 !== 16'h0000) begin errors++; $display("FAIL drop_idle_event: got %h expected 0000", score1); end
        cycle(STATE_PLAY, 1, 1, 0, 0);
        vectors++; if (score1 !== 16'h0000) begin errors++; $display("FAIL drop_no_rearm: got %h expected 0000", score1); end
        cycle(STATE_PLAY, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] got[10], exp[10];
        string       nm[10];
        int unsigned r;
        state_t      s;
        nm[0] = "score1"; nm[1] = "high1"; nm[2] = "tick1"; nm[3] = "sat1"; nm[4] = "nh1";
        nm[5] = "score2"; nm[6] = "high2"; nm[7] = "tick2"; nm[8] = "sat2"; nm[9] = "nh2";
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 15);
            s = (r == 0) ? STATE_IDLE : (r == 1) ? STATE_PAUSE : (r == 2) ? STATE_OVER : STATE_PLAY;
            cycle(s, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            got[0] = 32'(score1); exp[0] = to_bcd(m_score[0]);
            got[1] = 32'(high1);  exp[1] = to_bcd(m_high[0]);
            got[2] = 32'(tick1);  exp[2] = 32'(m_tick[0]);
            got[3] = 32'(sat1);   exp[3] = 32'(m_sat[0]);
            got[4] = 32'(nh1);    exp[4] = 32'(m_nh[0]);
            got[5] = 32'(score2); exp[5] = to_bcd(m_score[1]);
            got[6] = 32'(high2);  exp[6] = to_bcd(m_high[1]);
            got[7] = 32'(tick2);  exp[7] = 32'(m_tick[1]);
            got[8] = 32'(sat2);   exp[8] = 32'(m_sat[1]);
            got[9] = 32'(nh2);    exp[9] = 32'(m_nh[1]);
            for (int j = 0; j < 10; j++) begin
                vectors++;
                if (got[j] !== exp[j]) begin
                    errors++;
                    $display("FAIL rand_%s cycle %0d: got %h expected %h", nm[j], i, got[j], exp[j]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_ten_pulses();
        test_held_and_combined();
        test_saturation();
        test_reset_mid();
        test_high_score();
        test_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
